poly_compress_ctrl: RTL and testbench

Sequences one 256-coefficient polynomial through a single compress instance and packs the D-bit results into a byte stream, LSB-first, in ByteEncode_D order. Coefficients come from a synchronous-read coefficient RAM. Bytes go out over a valid/ready stream to the ciphertext serializer. Used for compressing u (D=10 or 11) and v (D=4 or 5), and for message encoding (D=1).

---
 rtl/poly_compress_ctrl_pkg.sv | 19 +
 rtl/poly_compress_ctrl_compress.sv | 20 ++
 rtl/poly_compress_ctrl.sv | 121 ++++++++++++
 tb/tb_poly_compress_ctrl.sv | 282 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/poly_compress_ctrl_pkg.sv
// Shared constants and state encoding for the polynomial compress/pack controller.
package poly_compress_ctrl_pkg;

    localparam int unsigned KYBER_N = 256;
    localparam int unsigned KYBER_Q = 3329;

    // floor(n / KYBER_Q) == (n * MULT) >> SHIFT holds exactly for every n < 2**25.
    localparam int unsigned KYBER_BARRETT_MULT  = 20642679;
    localparam int unsigned KYBER_BARRETT_SHIFT = 36;

    typedef enum logic [2:0] {
        StIdle,
        StRead,
        StCapt,
        StEmit,
        StDone
    } poly_compress_state_e;

endpackage

// File: rtl/poly_compress_ctrl_compress.sv
// Combinational Compress_D: round(2^D * x / q) mod 2^D, division done by Barrett multiply.
module poly_compress_ctrl_compress
    import poly_compress_ctrl_pkg::*;
#(
    parameter int unsigned D = 1
) (
    input  logic [11:0]  coeff,
    output logic [D-1:0] result
);

    logic [23:0] num;

    always_comb begin
        // q is odd, so adding floor(q/2) before flooring gives round-half-up.
        num    = (24'(coeff) << D) + 24'(KYBER_Q / 2);
        // Truncating to D bits performs the mod 2^D.
        result = D'((64'(num) * 64'(KYBER_BARRETT_MULT)) >> KYBER_BARRETT_SHIFT);
    end

endmodule

// File: rtl/poly_compress_ctrl.sv
// Streams one polynomial through compress and packs the D-bit results LSB-first into bytes.
module poly_compress_ctrl
    import poly_compress_ctrl_pkg::*;
#(
    parameter int unsigned D = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    output logic        busy,
    output logic        done,
    output logic        rd_en,
    output logic [7:0]  rd_addr,
    input  logic [11:0] rd_data,
    output logic [7:0]  out_data,
    output logic        out_valid,
    input  logic        out_ready
);

    poly_compress_state_e state_q, state_d;
    logic [7:0]  idx_q, idx_d;
    logic [23:0] acc_q, acc_d;
    logic [4:0]  cnt_q, cnt_d;

    logic        busy_q, busy_d;
    logic        done_q, done_d;
    logic        rd_en_q, rd_en_d;
    logic [7:0]  rd_addr_q, rd_addr_d;
    logic        out_valid_q, out_valid_d;
    logic [7:0]  out_data_q, out_data_d;

    logic [D-1:0] result;

    poly_compress_ctrl_compress #(
        .D(D)
    ) u_compress (
        .coeff (rd_data),
        .result(result)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d = StRead;
                    idx_d   = '0;
                    acc_d   = '0;
                    cnt_d   = '0;
                end
            end
            StRead: state_d = StCapt;
            StCapt: begin
                acc_d   = acc_q | (24'(result) << cnt_q);
                cnt_d   = cnt_q + 5'(D);
                state_d = StEmit;
            end
            StEmit: begin
                if (cnt_q >= 5'd8) begin
                    if (out_ready) begin
                        acc_d = acc_q >> 8;
                        cnt_d = cnt_q - 5'd8;
                    end
                end else if (idx_q == 8'(KYBER_N - 1)) begin
                    state_d = StDone;
                end else begin
                    state_d = StRead;
                    idx_d   = idx_q + 8'd1;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase

        // Outputs are registered, so they are derived from the next state.
        busy_d      = (state_d == StRead) || (state_d == StCapt) || (state_d == StEmit);
        done_d      = (state_d == StDone);
        rd_en_d     = (state_d == StRead);
        rd_addr_d   = rd_en_d ? idx_d : rd_addr_q;
        out_valid_d = (state_d == StEmit) && (cnt_d >= 5'd8);
        out_data_d  = out_valid_d ? acc_d[7:0] : out_data_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StIdle;
            idx_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            rd_en_q     <= 1'b0;
            rd_addr_q   <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            busy_q      <= busy_d;
            done_q      <= done_d;
            rd_en_q     <= rd_en_d;
            rd_addr_q   <= rd_addr_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign rd_en     = rd_en_q;
    assign rd_addr   = rd_addr_q;
    assign out_valid = out_valid_q;
    assign out_data  = out_data_q;

endmodule

// File: tb/tb_poly_compress_ctrl.sv
// Self-checking bench: one controller per legal D, each with its own coefficient RAM model.
module tb_poly_compress_ctrl;

    localparam int NI = 5;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic [NI-1:0] start = '0;
    logic [NI-1:0] out_ready = '1;
    logic [NI-1:0] busy, done, rd_en, out_valid;
    logic [7:0]  rd_addr  [NI];
    logic [7:0]  out_data [NI];
    logic [11:0] rd_data  [NI];
    logic [11:0] mem      [NI][256];

    int checks = 0;
    int errors = 0;
    int got_b [352];
    int exp_b [352];

    always #5 clk = ~clk;

    function automatic int d_of(input int g);
        case (g)
            0:       return 1;
            1:       return 4;
            2:       return 5;
            3:       return 10;
            default: return 11;
        endcase
    endfunction

    for (genvar g = 0; g < NI; g++) begin : g_dut
        localparam int unsigned DV = (g == 0) ? 1 : (g == 1) ? 4 : (g == 2) ? 5 :
                                     (g == 3) ? 10 : 11;
        poly_compress_ctrl #(.D(DV)) u_dut (
            .clk      (clk),
            .rst_n    (rst_n),
            .start    (start[g]),
            .busy     (busy[g]),
            .done     (done[g]),
            .rd_en    (rd_en[g]),
            .rd_addr  (rd_addr[g]),
            .rd_data  (rd_data[g]),
            .out_data (out_data[g]),
            .out_valid(out_valid[g]),
            .out_ready(out_ready[g])
        );
        always @(posedge clk) if (rd_en[g]) rd_data[g] <= mem[g][rd_addr[g]];
    end

    // Reference: compress every coefficient, lay bits into a flat stream, cut into bytes.
    task automatic build_expected(input int k);
        int dv;
        int c;
        bit stream [2816];
        dv = d_of(k);
        for (int i = 0; i < 256; i++) begin
            c = (((int'(mem[k][i]) * (1 << dv)) + 1664) / 3329) % (1 << dv);
            for (int j = 0; j < dv; j++) stream[i * dv + j] = bit'((c >> j) & 1);
        end
        for (int b = 0; b < 32 * dv; b++) begin
            exp_b[b] = 0;
            for (int t = 0; t < 8; t++) exp_b[b] = exp_b[b] | (int'(stream[8 * b + t]) << t);
        end
    endtask

    task automatic run_poly(input int k, input int stall_pct, input bit poke_start,
                            input int abort_at, output int nb, output bit saw_done);
        bit prev_stall;
        logic [7:0] prev_data;
        nb = 0;
        saw_done = 1'b0;
        prev_stall = 1'b0;
        prev_data = '0;
        @(negedge clk);
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        checks++;
        if (busy[k] !== 1'b1)
            begin errors++; $display("FAIL busy_after_start k=%0d got %b want 1", k, busy[k]); end
        for (int cyc = 0; cyc < 20000; cyc++) begin
            if (done[k] === 1'b1) begin saw_done = 1'b1; break; end
            if (prev_stall) begin
                checks++;
                if (out_valid[k] !== 1'b1 || out_data[k] !== prev_data) begin
                    errors++;
                    $display("FAIL stall_hold k=%0d got v=%b d=%h want v=1 d=%h",
                             k, out_valid[k], out_data[k], prev_data);
                end
                checks++;
                if (rd_en[k] !== 1'b0)
                    begin errors++; $display("FAIL rd_in_stall k=%0d got %b want 0", k, rd_en[k]); end
            end
            if (abort_at >= 0 && nb == abort_at) begin
                start[k] = 1'b0;
                return;
            end
            out_ready[k] = ($urandom_range(99) >= stall_pct);
            if (out_valid[k] && out_ready[k]) begin
                if (nb < 352) got_b[nb] = int'(out_data[k]);
                nb++;
            end
            prev_stall = out_valid[k] && !out_ready[k];
            prev_data = out_data[k];
            start[k] = poke_start && busy[k] && ($urandom_range(3) == 0);
            @(negedge clk);
        end
        start[k] = 1'b0;
        out_ready[k] = 1'b1;
        checks++;
        if (!saw_done) begin errors++; $display("FAIL done_timeout k=%0d got none want done", k); end
    endtask

    // Called at the done cycle: busy low, start here is ignored, no second done.
    task automatic finish_checks(input int k);
        checks++;
        if (busy[k] !== 1'b0)
            begin errors++; $display("FAIL busy_at_done k=%0d got %b want 0", k, busy[k]); end
        start[k] = 1'b1;
        @(negedge clk);
        start[k] = 1'b0;
        for (int i = 0; i < 4; i++) begin
            checks++;
            if (done[k] !== 1'b0 || busy[k] !== 1'b0 || rd_en[k] !== 1'b0) begin
                errors++;
                $display("FAIL idle_after_done k=%0d got done=%b busy=%b rd=%b want 0 0 0",
                         k, done[k], busy[k], rd_en[k]);
            end
            @(negedge clk);
        end
    endtask

    task automatic check_stream(input int k, input int nb, input string tag);
        int n;
        n = 32 * d_of(k);
        checks++;
        if (nb != n) begin errors++; $display("FAIL %s_count got %0d want %0d", tag, nb, n); end
        for (int b = 0; b < n && b < nb; b++) begin
            checks++;
            if (got_b[b] != exp_b[b]) begin
                errors++;
                $display("FAIL %s_byte%0d got %h want %h", tag, b, got_b[b], exp_b[b]);
            end
        end
    endtask

    task automatic test_reset();
        #1;
        for (int k = 0; k < NI; k++) begin
            checks++;
            if (busy[k] !== 0 || done[k] !== 0 || rd_en[k] !== 0 || rd_addr[k] !== 0 ||
                out_valid[k] !== 0 || out_data[k] !== 0) begin
                errors++;
                $display("FAIL reset_outputs k=%0d got b=%b d=%b r=%b a=%h v=%b o=%h want all 0",
                         k, busy[k], done[k], rd_en[k], rd_addr[k], out_valid[k], out_data[k]);
            end
        end
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_fill(input int k, input int val, input string tag, input int want);
        int nb;
        bit sd;
        for (int i = 0; i < 256; i++) mem[k][i] = 12'(val);
        build_expected(k);
        run_poly(k, 0, 1'b0, -1, nb, sd);
        if (sd) finish_checks(k);
        check_stream(k, nb, tag);
        for (int b = 0; b < nb && b < 32 * d_of(k); b++) begin
            checks++;
            if (got_b[b] != want)
                begin errors++; $display("FAIL %s_const%0d got %h want %h", tag, b, got_b[b], want); end
        end
    endtask

    task automatic test_d11_single();
        int nb;
        bit sd;
        for (int i = 0; i < 256; i++) mem[4][i] = 12'd0;
        mem[4][0] = 12'd1664;
        build_expected(4);
        run_poly(4, 0, 1'b0, -1, nb, sd);
        if (sd) finish_checks(4);
        check_stream(4, nb, "d11_single");
        checks++;
        if (got_b[0] != 0 || got_b[1] != 4) begin
            errors++;
            $display("FAIL d11_first_bytes got %h %h want 00 04", got_b[0], got_b[1]);
        end
    endtask

    task automatic test_d4_stall();
        int nb;
        bit sd;
        int nib;
        for (int i = 0; i < 256; i++) mem[1][i] = 12'((i % 16) * 208);
        build_expected(1);
        run_poly(1, 40, 1'b0, -1, nb, sd);
        if (sd) finish_checks(1);
        check_stream(1, nb, "d4_stall");
        for (int b = 0; b < nb && b < 128; b++) begin
            nib = (b % 8) * 2;
            checks++;
            if (got_b[b] != (((nib + 1) << 4) | nib))
                begin errors++; $display("FAIL d4_pattern%0d got %h want %h", b, got_b[b],
                                         ((nib + 1) << 4) | nib); end
        end
    endtask

    task automatic test_d5_abort();
        int nb;
        bit sd;
        for (int i = 0; i < 256; i++) mem[2][i] = 12'($urandom_range(3328));
        build_expected(2);
        run_poly(2, 20, 1'b1, 40, nb, sd);
        rst_n = 1'b0;
        #1;
        checks++;
        if (busy[2] !== 0 || done[2] !== 0 || rd_en[2] !== 0 || rd_addr[2] !== 0 ||
            out_valid[2] !== 0 || out_data[2] !== 0) begin
            errors++;
            $display("FAIL abort_outputs got b=%b d=%b r=%b a=%h v=%b o=%h want all 0",
                     busy[2], done[2], rd_en[2], rd_addr[2], out_valid[2], out_data[2]);
        end
        out_ready[2] = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            checks++;
            if (done[2] !== 1'b0 || busy[2] !== 1'b0)
                begin errors++; $display("FAIL abort_no_done got done=%b busy=%b want 0 0",
                                         done[2], busy[2]); end
        end
        run_poly(2, 20, 1'b1, -1, nb, sd);
        if (sd) finish_checks(2);
        check_stream(2, nb, "d5_fresh");
    endtask

    task automatic test_random_all();
        int nb;
        bit sd;
        for (int k = 0; k < NI; k++) begin
            for (int i = 0; i < 256; i++) mem[k][i] = 12'($urandom_range(3328));
            build_expected(k);
            run_poly(k, $urandom_range(50), 1'b1, -1, nb, sd);
            if (sd) finish_checks(k);
            check_stream(k, nb, "random");
        end
    endtask

    // Out-of-contract coefficients: values don't care, count and termination still matter.
    task automatic test_out_of_range();
        int nb;
        bit sd;
        for (int i = 0; i < 256; i++) mem[3][i] = 12'($urandom_range(4095, 3329));
        run_poly(3, 10, 1'b0, -1, nb, sd);
        if (sd) finish_checks(3);
        checks++;
        if (nb != 320) begin errors++; $display("FAIL oor_count got %0d want 320", nb); end
    endtask

    initial begin
        test_reset();
        test_fill(0, 0, "d1_zero", 8'h00);
        test_fill(0, 1665, "d1_ones", 8'hFF);
        test_fill(3, 3328, "d10_wrap", 8'h00);
        test_d11_single();
        test_d4_stall();
        test_d5_abort();
        test_random_all();
        test_out_of_range();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
